// File: rtl/cache_mem_pkg.sv
// Shared types for the cache/memory write-back path: widths, FSM states and
// the queued write-back entry layout.
package cache_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } wbb_state_e;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo_cam.sv
// Circular write-back queue with an associative lookup that returns the
// newest matching entry, including a same-cycle incoming push.
module wb_fifo_cam #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH-1:0] head_addr_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] hit_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  always_ff @(posedge clock_i) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Scan oldest to newest so the last match wins; an accepted push is newer still.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (addr_q[rd_ptr_q + PW'(k)] == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[rd_ptr_q + PW'(k)];
      end
    end
    if (do_push && (push_addr_i == lookup_addr_i)) begin
      hit_o      = 1'b1;
      hit_data_o = push_data_i;
    end
  end

endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer between the data cache and memory: queues evictions,
// drains them in the background and serves refills with read priority.
module write_back_buffer
  import cache_mem_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_req,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  wbb_state_e            state_q, state_d;
  logic                  rd_busy_q, rd_busy_d, rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  fifo_full, fifo_empty, fifo_pop, hit;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data, hit_data;
  logic                  wb_push, rd_fire, rd_miss;

  assign wb_ready = !fifo_full;
  assign wb_push  = wb_req && !fifo_full;
  assign rd_fire  = rd_req && !rd_busy_q;
  assign rd_miss  = rd_fire && !hit;
  assign fifo_pop = (state_q == WR_WAIT) && mem_ack;
  assign rd_busy  = rd_busy_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  wb_fifo_cam #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock_i       (clock),
    .reset_i       (reset),
    .push_i        (wb_req),
    .push_addr_i   (wb_addr),
    .push_data_i   (wb_data),
    .pop_i         (fifo_pop),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .lookup_addr_i (rd_addr),
    .hit_o         (hit),
    .hit_data_o    (hit_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Deciding on this cycle's miss/push lets mem_req rise the very next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_busy_q || rd_miss)      state_d = RD_WAIT;
        else if (!fifo_empty || wb_push) state_d = WR_WAIT;
      end
      RD_WAIT: if (mem_ack) state_d = IDLE;
      WR_WAIT: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      RD_WAIT: begin
        mem_req  = 1'b1;
        mem_addr = pend_addr_q;
      end
      WR_WAIT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_busy_d   = rd_busy_q;
    pend_addr_d = pend_addr_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    if (rd_fire) begin
      if (hit) begin
        rd_valid_d = 1'b1;
        rd_data_d  = hit_data;
      end else begin
        rd_busy_d   = 1'b1;
        pend_addr_d = rd_addr;
      end
    end
    if ((state_q == RD_WAIT) && mem_ack) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_rdata;
      rd_busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_busy_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      pend_addr_q <= '0;
      rd_data_q   <= '0;
    end else begin
      rd_busy_q   <= rd_busy_d;
      rd_valid_q  <= rd_valid_d;
      pend_addr_q <= pend_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always @(posedge clock) begin
    if (!reset) assert (!(wb_req && fifo_full)) else $error("wb_req pulsed while buffer full");
  end

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed bench for write_back_buffer: scoreboards for memory transactions
// and refill data, plus cycle-level checks on handshake timing.
module tb_write_back_buffer;
  import cache_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct packed {
    logic      we;
    wb_entry_t e;
  } txn_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wb_req = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_ready;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_busy, rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  txn_t          exp_mem[$];
  logic [DW-1:0] exp_rd[$];
  txn_t          mon_t;
  logic [DW-1:0] mon_d;

  always #5 clock = ~clock;

  write_back_buffer #(.DEPTH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .wb_req    (wb_req),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_wb(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_drain);
    txn_t t;
    wb_req  = 1'b1;
    wb_addr = a;
    wb_data = d;
    if (expect_drain) begin
      t.we = 1'b1; t.e.addr = a; t.e.data = d;
      exp_mem.push_back(t);
    end
  endtask

  task automatic drive_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_miss);
    txn_t t;
    rd_req  = 1'b1;
    rd_addr = a;
    exp_rd.push_back(d);
    if (expect_miss) begin
      t.we = 1'b0; t.e.addr = a; t.e.data = '0;
      exp_mem.push_back(t);
    end
  endtask

  task automatic serve(input int delay, input logic [DW-1:0] rdata);
    int n = 0;
    while (!mem_req && n < 50) begin
      cyc(1);
      n++;
    end
    checks++;
    assert (mem_req) else begin
      errors++;
      $error("FAIL serve_timeout: observed mem_req=0 expected 1 within 50 cycles");
    end
    if (delay > 0) cyc(delay);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    cyc(1);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // Scoreboard side: every completed handshake and every refill pops one entry.
  always @(negedge clock) begin
    if (!reset && mem_req && mem_ack) begin
      checks++;
      assert (exp_mem.size() != 0) else begin
        errors++;
        $error("FAIL mem_txn_unexpected: observed we=%0b addr=0x%0h expected no transaction", mem_we, mem_addr);
      end
      if (exp_mem.size() != 0) begin
        mon_t = exp_mem.pop_front();
        check("mem_we", 64'(mem_we), 64'(mon_t.we));
        check("mem_addr", 64'(mem_addr), 64'(mon_t.e.addr));
        if (mon_t.we) check("mem_wdata", mem_wdata, mon_t.e.data);
      end
    end
    if (!reset && rd_valid) begin
      checks++;
      assert (exp_rd.size() != 0) else begin
        errors++;
        $error("FAIL rd_valid_unexpected: observed rd_data=0x%0h expected no refill", rd_data);
      end
      if (exp_rd.size() != 0) begin
        mon_d = exp_rd.pop_front();
        check("rd_data", rd_data, mon_d);
      end
    end
  end

  initial begin
    // Reset state
    cyc(2);
    check("rst_wb_ready", 64'(wb_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_rd_busy", 64'(rd_busy), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    reset = 1'b0;
    cyc(1);

    // Single write-back drains the cycle after it is queued
    drive_wb(32'h10, 64'hAAAA_5555_AAAA_5555, 1'b1);
    cyc(1);
    wb_req = 1'b0;
    check("s1_mem_req", 64'(mem_req), 64'd1);
    check("s1_mem_we", 64'(mem_we), 64'd1);
    check("s1_mem_addr", 64'(mem_addr), 64'h10);
    cyc(2);
    mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    check("s1_req_drop", 64'(mem_req), 64'd0);
    check("s1_wb_ready", 64'(wb_ready), 64'd1);
    cyc(1);
    check("s1_empty_idle", 64'(mem_req), 64'd0);

    // Fill to DEPTH with ack held low
    for (int i = 1; i <= 4; i++) begin
      drive_wb(32'(i), 64'h1000 + 64'(i), 1'b1);
      cyc(1);
      if (i == 3) check("s2_ready_at3", 64'(wb_ready), 64'd1);
    end
    wb_req = 1'b0;
    check("s2_full", 64'(wb_ready), 64'd0);
    check("s2_head", 64'(mem_addr), 64'h1);
    mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    check("s2_ready_after_pop", 64'(wb_ready), 64'd1);
    for (int i = 0; i < 3; i++) serve(0, '0);

    // Forward from the entry currently being drained
    drive_wb(32'h20, 64'h1122_3344_5566_7788, 1'b1);
    cyc(1);
    wb_req = 1'b0;
    check("s3_drain_addr", 64'(mem_addr), 64'h20);
    drive_rd(32'h20, 64'h1122_3344_5566_7788, 1'b0);
    cyc(1);
    rd_req = 1'b0;
    check("s3_fwd_valid", 64'(rd_valid), 64'd1);
    check("s3_fwd_no_busy", 64'(rd_busy), 64'd0);
    cyc(1);
    check("s3_still_write", 64'(mem_we), 64'd1);
    serve(1, '0);

    // Newest of two entries with the same address wins
    drive_wb(32'h40, 64'hAAAA_0000_0000_000A, 1'b1);
    cyc(1);
    drive_wb(32'h40, 64'hBBBB_0000_0000_000B, 1'b1);
    cyc(1);
    wb_req = 1'b0;
    drive_rd(32'h40, 64'hBBBB_0000_0000_000B, 1'b0);
    cyc(1);
    rd_req = 1'b0;
    check("s4_newest_valid", 64'(rd_valid), 64'd1);
    serve(0, '0);
    serve(0, '0);

    // Write-before-read in the same cycle
    drive_wb(32'h60, 64'hCCCC_6060_CCCC_6060, 1'b1);
    drive_rd(32'h60, 64'hCCCC_6060_CCCC_6060, 1'b0);
    cyc(1);
    wb_req = 1'b0;
    rd_req = 1'b0;
    check("s4b_wbr_valid", 64'(rd_valid), 64'd1);
    check("s4b_wbr_no_busy", 64'(rd_busy), 64'd0);
    serve(0, '0);

    // Read miss from memory; a second rd_req while busy is ignored
    drive_rd(32'h30, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    cyc(1);
    rd_req = 1'b0;
    check("s5_mem_req", 64'(mem_req), 64'd1);
    check("s5_mem_we", 64'(mem_we), 64'd0);
    check("s5_mem_addr", 64'(mem_addr), 64'h30);
    check("s5_busy0", 64'(rd_busy), 64'd1);
    rd_req  = 1'b1;
    rd_addr = 32'h99;
    cyc(1);
    rd_req = 1'b0;
    check("s5_busy1", 64'(rd_busy), 64'd1);
    check("s5_addr_held", 64'(mem_addr), 64'h30);
    cyc(1);
    check("s5_busy2", 64'(rd_busy), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    check("s5_no_early_valid", 64'(rd_valid), 64'd0);
    cyc(1);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("s5_valid", 64'(rd_valid), 64'd1);
    check("s5_busy_clear", 64'(rd_busy), 64'd0);
    cyc(1);
    check("s5_valid_pulse", 64'(rd_valid), 64'd0);

    // Miss during an active drain waits for the write ack
    drive_wb(32'h70, 64'h7070_7070_7070_7070, 1'b1);
    cyc(1);
    wb_req = 1'b0;
    drive_rd(32'h50, 64'h5050_EEEE_5050_EEEE, 1'b1);
    cyc(1);
    rd_req = 1'b0;
    check("s6_busy", 64'(rd_busy), 64'd1);
    check("s6_write_first", 64'(mem_we), 64'd1);
    check("s6_write_addr", 64'(mem_addr), 64'h70);
    cyc(1);
    check("s6_write_held", 64'(mem_we), 64'd1);
    mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    check("s6_gap", 64'(mem_req), 64'd0);
    cyc(1);
    check("s6_read_req", 64'(mem_req), 64'd1);
    check("s6_read_we", 64'(mem_we), 64'd0);
    check("s6_read_addr", 64'(mem_addr), 64'h50);
    serve(1, 64'h5050_EEEE_5050_EEEE);

    // Asynchronous reset in the middle of RD_WAIT with a full FIFO
    rd_req  = 1'b1;
    rd_addr = 32'h80;
    cyc(1);
    rd_req = 1'b0;
    check("s7_rd_wait", 64'(mem_req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive_wb(32'h90 + 32'(i), 64'(i), 1'b0);
      cyc(1);
    end
    wb_req = 1'b0;
    check("s7_full", 64'(wb_ready), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("s7_rst_req", 64'(mem_req), 64'd0);
    check("s7_rst_busy", 64'(rd_busy), 64'd0);
    check("s7_rst_ready", 64'(wb_ready), 64'd1);
    cyc(1);
    reset = 1'b0;
    cyc(3);
    check("s7_post_idle", 64'(mem_req), 64'd0);
    check("s7_post_valid", 64'(rd_valid), 64'd0);

    check("sb_mem_empty", 64'(exp_mem.size()), 64'd0);
    check("sb_rd_empty", 64'(exp_rd.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_back_buffer.md
Name: write_back_buffer

Overview:
- Sits between data_cache and main memory.
- Queues dirty-block evictions from the cache in a small FIFO and drains them to memory in the background.
- Serves cache refill reads from memory, with priority over draining.
- Forwards refill data straight from the FIFO when the requested block is still queued, so the cache never reads stale memory.

Parameters:
- DEPTH, 4, number of queued write-back entries (power of 2, >=2).
- ADDR_WIDTH, 32, block address width; matches the cache {tag,set} address, zero-extended.
- DATA_WIDTH, 64, block width (8 bytes).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- wb_req  in  1  cache write-back request, 1-cycle pulse (cache mem_wren).
- wb_addr  in  ADDR_WIDTH  block address of evicted line.
- wb_data  in  DATA_WIDTH  evicted block.
- wb_ready  out  1  1 = an entry is free; cache must not pulse wb_req while 0.
- rd_req  in  1  refill request, 1-cycle pulse.
- rd_addr  in  ADDR_WIDTH  block address to fetch.
- rd_busy  out  1  1 = a refill is in progress; further rd_req are ignored.
- rd_valid  out  1  1-cycle pulse, rd_data valid.
- rd_data  out  DATA_WIDTH  refill block to the cache (cache mem_data).
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
- mem_addr  out  ADDR_WIDTH  memory block address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ack  in  1  1-cycle completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (asynchronous): all outputs 0 except wb_ready = 1; FIFO empty; state IDLE; pending-read register cleared.
- Reset mid-handshake: mem_req drops immediately; memory must discard the abandoned transaction.
- FIFO: circular buffer with wr_ptr, rd_ptr and a count of width clog2(DEPTH)+1; pointers wrap at DEPTH.
  - wb_ready = (count != DEPTH), registered state only; no same-cycle bypass on pop.
- Push: when wb_req && wb_ready, store {wb_addr, wb_data}; count+1 on the next edge.
  - wb_req while full is ignored. This is a protocol error, checked by an assertion.
- Pop: when mem_ack arrives in WR_WAIT, count-1. Push and pop in the same cycle leave count unchanged.
- Forwarding on rd_req:
  - Compare rd_addr against all valid entries, including an entry currently being drained.
  - On a match, the newest entry wins; its data is returned with rd_valid in cycle N+1, and no memory read is issued.
  - If wb_req in the same cycle carries the same address, the incoming wb_data is forwarded (write-before-read).
- Read miss (no match): latch rd_addr into the pending register and set rd_busy.
- State machine:
  - IDLE: pending read -> mem_req=1, mem_we=0, mem_addr=pending addr -> RD_WAIT. Otherwise, FIFO non-empty -> mem_req=1, mem_we=1, head addr/data -> WR_WAIT. Otherwise stay in IDLE.
  - RD_WAIT: on mem_ack, drop mem_req, register mem_rdata to rd_data, assert rd_valid next cycle, clear rd_busy with rd_valid -> IDLE.
  - WR_WAIT: on mem_ack, drop mem_req, pop head -> IDLE. A read arriving here is latched as pending and issued only after the write completes; an in-flight handshake is never aborted.
- Reads have priority in IDLE; a drain starts only when no read is pending.
- Minimum latencies:
  - Forwarded read: 1 cycle.
  - Miss: rd_req at N, mem_req at N+1, mem_ack at M >= N+1, rd_valid at M+1.
  - Miss during an active drain: add the drain's remaining cycles plus 1.
- mem_req deasserts for at least 1 cycle between transactions (every transaction returns to IDLE).
- rd_req while rd_busy is ignored; a forwarded read never sets rd_busy.

Decomposition:
- Package cache_mem_pkg: ADDR_WIDTH/DATA_WIDTH defaults, state encoding (IDLE, RD_WAIT, WR_WAIT), wb_entry struct {addr, data}.
- Sub-module wb_fifo_cam: storage, pointers, count, and associative newest-match lookup (outputs hit, hit_data).
- The top level holds the FSM, pending-read register and output registers.

Test Plan:
- Reset, then wb_req addr=0x10 data=0xAAAA_5555_AAAA_5555 -> next cycle mem_req=1, mem_we=1, mem_addr=0x10; mem_ack 3 cycles later -> count returns to 0, mem_req=0.
- Hold mem_ack=0, pulse 4 writes (0x1..0x4) -> wb_ready=0 after the 4th; one ack pops 0x1 first, wb_ready=1 the next cycle.
- Queued 0x20 -> 0x1122_3344_5566_7788 (ack held low); rd_req 0x20 -> rd_valid next cycle with that data; no mem_we=0 request seen.
- Two writes to 0x40 (A, then B), then rd_req 0x40 -> rd_data=B.
- Empty FIFO, rd_req 0x30; memory acks 2 cycles after mem_req with 0xDEAD_BEEF_CAFE_F00D -> rd_valid the cycle after ack; rd_busy high throughout.
- Drain in WR_WAIT, then rd_req 0x50 (miss) -> read issued only after the write ack. Separately, assert reset mid-RD_WAIT -> mem_req and rd_busy drop immediately, wb_ready=1, count=0.
